// File: rtl/nco_quadrant_fold_if.sv
// Signal bundle between the NCO/quadrant folder and its surroundings:
// frequency/phase control, the first-quadrant core link and signed full-circle results.
interface nco_quadrant_fold_if #(
    parameter int ASIZE = 16,
    parameter int DSIZE = 16
);
    localparam int PSIZE = ASIZE + 2;

    logic             clr;
    logic             freq_we;
    logic [PSIZE-1:0] freq_in;
    logic [PSIZE-1:0] offset;
    logic             step_en;
    logic [ASIZE-1:0] core_angle;
    logic [DSIZE-1:0] core_cos;
    logic [DSIZE-1:0] core_sin;
    logic             out_valid;
    logic [DSIZE:0]   out_cos;
    logic [DSIZE:0]   out_sin;
    logic [1:0]       out_quad;

    modport slave (
        input  clr, freq_we, freq_in, offset, step_en, core_cos, core_sin,
        output core_angle, out_valid, out_cos, out_sin, out_quad
    );

    modport master (
        output clr, freq_we, freq_in, offset, step_en, core_cos, core_sin,
        input  core_angle, out_valid, out_cos, out_sin, out_quad
    );
endinterface

// File: rtl/nco_quadrant_fold.sv
// Phase accumulator that folds each full-circle sample into a first-quadrant angle for the
// CORDIC core, then restores signs of the returned cos/sin using a latency-matched quadrant tag.
module nco_quadrant_fold #(
    parameter int ASIZE    = 16,
    parameter int DSIZE    = 16,
    parameter int CORE_LAT = 18
) (
    input  logic                clock,
    input  logic                rst_n,
    nco_quadrant_fold_if.slave  bus
);
    localparam int PSIZE = ASIZE + 2;

    logic [PSIZE-1:0] acc;
    logic [PSIZE-1:0] freq;
    logic [PSIZE-1:0] p_reg;
    logic [PSIZE-1:0] phase;
    logic [CORE_LAT:0] vpipe;
    logic [1:0]        qpipe [0:CORE_LAT];
    logic [DSIZE:0]    c_ext;
    logic [DSIZE:0]    s_ext;
    logic [DSIZE:0]    cos_nxt;
    logic [DSIZE:0]    sin_nxt;
    logic [1:0]        q_out;

    assign phase          = acc + bus.offset;
    assign bus.core_angle = p_reg[ASIZE-1:0];
    assign c_ext          = {1'b0, bus.core_cos};
    assign s_ext          = {1'b0, bus.core_sin};
    assign q_out          = qpipe[CORE_LAT];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            freq  <= '0;
            p_reg <= '0;
        end else begin
            if (bus.freq_we) freq <= bus.freq_in;
            // the step uses the frequency held before this edge, even if freq_we is also set
            if (bus.clr) begin
                acc <= '0;
            end else if (bus.step_en) begin
                p_reg <= phase;
                acc   <= acc + freq;
            end
        end
    end

    // The tag is captured every cycle; only the valid bit marks a real sample.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
            for (int i = 0; i <= CORE_LAT; i++) qpipe[i] <= 2'd0;
        end else begin
            vpipe    <= bus.clr ? '0 : {vpipe[CORE_LAT-1:0], bus.step_en};
            qpipe[0] <= phase[PSIZE-1:ASIZE];
            for (int i = 1; i <= CORE_LAT; i++) qpipe[i] <= qpipe[i-1];
        end
    end

    always_comb begin
        cos_nxt = c_ext;
        sin_nxt = s_ext;
        case (q_out)
            2'd0: begin cos_nxt = c_ext;  sin_nxt = s_ext;  end
            2'd1: begin cos_nxt = -s_ext; sin_nxt = c_ext;  end
            2'd2: begin cos_nxt = -c_ext; sin_nxt = -s_ext; end
            default: begin cos_nxt = s_ext; sin_nxt = -c_ext; end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_cos   <= '0;
            bus.out_sin   <= '0;
            bus.out_quad  <= 2'd0;
        end else begin
            bus.out_valid <= vpipe[CORE_LAT] & ~bus.clr;
            if (vpipe[CORE_LAT] && !bus.clr) begin
                bus.out_cos  <= cos_nxt;
                bus.out_sin  <= sin_nxt;
                bus.out_quad <= q_out;
            end
        end
    end
endmodule

// File: tb/tb_nco_quadrant_fold.sv
// Directed bench for nco_quadrant_fold: a constant-output core model, a negedge monitor
// collecting emitted samples, and hand-computed expected values.
module tb_nco_quadrant_fold;
    localparam int ASIZE    = 16;
    localparam int DSIZE    = 16;
    localparam int CORE_LAT = 18;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic [35:0] oq[$];
    int          ot[$];

    nco_quadrant_fold_if #(.ASIZE(ASIZE), .DSIZE(DSIZE)) bus ();

    nco_quadrant_fold #(.ASIZE(ASIZE), .DSIZE(DSIZE), .CORE_LAT(CORE_LAT)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign bus.core_cos = 16'h1234;
    assign bus.core_sin = 16'h0056;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (bus.out_valid) begin
            oq.push_back({bus.out_quad, bus.out_cos, bus.out_sin});
            ot.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_out(input int n, input int budget);
        int b;
        b = budget;
        while (oq.size() < n && b > 0) begin
            tick();
            b--;
        end
        check("wait_count", 64'(oq.size()), 64'(n));
    endtask

    task automatic pop_check(input string tag, input logic [35:0] exp);
        logic [35:0] v;
        if (oq.size() > 0) begin
            v = oq.pop_front();
            check(tag, 64'(v), 64'(exp));
        end else begin
            check({tag, "_missing"}, 64'(0), 64'(exp));
        end
    endtask

    initial begin
        logic [35:0] exp1 [4];
        logic [35:0] v;
        int          start;

        exp1[0] = {2'd0, 17'h01234, 17'h00056};
        exp1[1] = {2'd1, 17'h1FFAA, 17'h01234};
        exp1[2] = {2'd2, 17'h1EDCC, 17'h1FFAA};
        exp1[3] = {2'd3, 17'h00056, 17'h1EDCC};

        bus.clr = 1'b0; bus.freq_we = 1'b0; bus.freq_in = '0;
        bus.offset = '0; bus.step_en = 1'b0;
        repeat (3) tick();
        check("rst_angle", 64'(bus.core_angle), 64'(0));
        check("rst_valid", 64'(bus.out_valid), 64'(0));
        check("rst_cos", 64'(bus.out_cos), 64'(0));
        rst_n = 1'b1;
        tick();

        // quadrant walk
        bus.freq_we = 1'b1; bus.freq_in = 18'h10000; tick(); bus.freq_we = 1'b0;
        bus.step_en = 1'b1; repeat (4) tick(); bus.step_en = 1'b0;
        wait_out(4, 40);
        for (int i = 0; i < 4; i++) pop_check($sformatf("quad%0d", i), exp1[i]);

        // negative-going frequency
        bus.clr = 1'b1; bus.freq_we = 1'b1; bus.freq_in = 18'h3FFFF; tick();
        bus.clr = 1'b0; bus.freq_we = 1'b0;
        bus.step_en = 1'b1; tick();
        check("neg_angle0", 64'(bus.core_angle), 64'(16'h0000));
        tick(); bus.step_en = 1'b0;
        check("neg_angle1", 64'(bus.core_angle), 64'(16'hFFFF));
        wait_out(2, 40);
        pop_check("neg_out0", exp1[0]);
        pop_check("neg_out1", exp1[3]);

        // continuous stream
        oq.delete(); ot.delete();
        start = cyc + 1;
        bus.step_en = 1'b1; repeat (20) tick(); bus.step_en = 1'b0;
        repeat (40) tick();
        check("stream_count", 64'(oq.size()), 64'(20));
        if (ot.size() >= 20) begin
            check("stream_latency", 64'(ot[0] - start), 64'(CORE_LAT + 1));
            check("stream_span", 64'(ot[19] - ot[0]), 64'(19));
        end

        // clr beats step_en
        bus.clr = 1'b1; bus.freq_we = 1'b1; bus.freq_in = 18'h12345; tick();
        bus.clr = 1'b0; bus.freq_we = 1'b0;
        bus.step_en = 1'b1; tick(); bus.step_en = 1'b0;
        repeat (25) tick();
        oq.delete();
        bus.offset = 18'h00ABC; bus.clr = 1'b1; bus.step_en = 1'b1; tick();
        bus.clr = 1'b0; bus.step_en = 1'b0;
        check("clr_hold_angle", 64'(bus.core_angle), 64'(16'h0000));
        repeat (25) tick();
        check("clr_no_valid", 64'(oq.size()), 64'(0));
        bus.step_en = 1'b1; tick(); bus.step_en = 1'b0;
        check("clr_next_angle", 64'(bus.core_angle), 64'(16'h0ABC));
        wait_out(1, 40);
        if (oq.size() > 0) begin
            v = oq.pop_front();
            check("clr_next_quad", 64'(v[35:34]), 64'(2'd0));
        end

        // reset with samples in flight
        bus.offset = 18'h10000;
        oq.delete();
        bus.step_en = 1'b1; repeat (5) tick(); bus.step_en = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("arst_cos", 64'(bus.out_cos), 64'(0));
        check("arst_sin", 64'(bus.out_sin), 64'(0));
        check("arst_quad", 64'(bus.out_quad), 64'(0));
        check("arst_angle", 64'(bus.core_angle), 64'(0));
        check("arst_valid", 64'(bus.out_valid), 64'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (30) tick();
        check("arst_no_valid", 64'(oq.size()), 64'(0));

        // freq_we alongside step_en
        bus.offset = '0;
        bus.freq_we = 1'b1; bus.freq_in = 18'h00001; tick();
        bus.freq_in = 18'h00002; bus.step_en = 1'b1; tick();
        bus.freq_we = 1'b0;
        check("fwe_s0", 64'(bus.core_angle), 64'(0));
        tick();
        check("fwe_s1", 64'(bus.core_angle), 64'(1));
        tick();
        check("fwe_s2", 64'(bus.core_angle), 64'(3));
        bus.step_en = 1'b0;
        repeat (25) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
